// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux between four requesters, with a hold quantum.
// Optional build macro MUX_ARB_LOCK_EN adds a 'lock' input that suppresses preemption.
module mux4_rr_arbiter #(
    parameter int W        = 1,
    parameter int HOLD_MAX = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req,
    input  logic [W-1:0] x0,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] x2,
    input  logic [W-1:0] x3,
`ifdef MUX_ARB_LOCK_EN
    input  logic         lock,
`endif
    output logic [3:0]   gnt,
    output logic         s1,
    output logic         s0,
    output logic         valid,
    output logic [W-1:0] y
);

    localparam int CW = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_MAX - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t        state_q;
    logic [3:0]    gnt_q;
    logic [1:0]    sel_q;
    logic          valid_q;
    logic [1:0]    ptr_q;
    logic [CW-1:0] cnt_q;

    logic [2:0]    idle_pick_s;
    logic [2:0]    next_pick_s;
    logic          release_s;
    logic          preempt_s;
    logic          lock_s;

    // First set bit of r, scanning start, start+1, ... mod 4; returns {found, index}.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (r[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

`ifdef MUX_ARB_LOCK_EN
    assign lock_s = lock;
`else
    assign lock_s = 1'b0;
`endif

    // Arbitration decisions for the current cycle.
    always_comb begin
        idle_pick_s = rr_pick(req, ptr_q);
        // The current holder is masked out, so one search serves both release and preempt.
        next_pick_s = rr_pick(req & ~gnt_q, sel_q + 2'd1);
        release_s   = ~|(req & gnt_q);
        preempt_s   = (cnt_q == CNT_MAX) && (|(req & ~gnt_q)) && !lock_s;
    end

    // Grant state machine with registered grant, select and valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'b00;
            valid_q <= 1'b0;
            ptr_q   <= 2'b00;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (idle_pick_s[2]) begin
                        state_q <= ST_GRANT;
                        gnt_q   <= 4'b0001 << idle_pick_s[1:0];
                        sel_q   <= idle_pick_s[1:0];
                        valid_q <= 1'b1;
                        ptr_q   <= idle_pick_s[1:0] + 2'd1;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    if (release_s || preempt_s) begin
                        if (next_pick_s[2]) begin
                            gnt_q <= 4'b0001 << next_pick_s[1:0];
                            sel_q <= next_pick_s[1:0];
                            ptr_q <= next_pick_s[1:0] + 2'd1;
                            cnt_q <= '0;
                        end else begin
                            // Select lines keep their last value while idle.
                            state_q <= ST_IDLE;
                            gnt_q   <= 4'b0000;
                            valid_q <= 1'b0;
                            cnt_q   <= '0;
                        end
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + CW'(1);
                    end else begin
                        cnt_q <= cnt_q;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= 4'b0000;
                    valid_q <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign gnt   = gnt_q;
    assign s1    = sel_q[1];
    assign s0    = sel_q[0];
    assign valid = valid_q;

    // Gated mux output; zero whenever no grant is active.
    always_comb begin
        y = '0;
        if (valid_q) begin
            case (sel_q)
                2'd0:    y = x0;
                2'd1:    y = x1;
                2'd2:    y = x2;
                2'd3:    y = x3;
                default: y = '0;
            endcase
        end else begin
            y = '0;
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios plus randomized traffic
// compared against an integer-level round-robin reference model.
module tb_mux4_rr_arbiter;

    localparam int W        = 4;
    localparam int HOLD_MAX = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [3:0]   req = 4'b0000;
    logic [W-1:0] xv [4];
    logic         lock_v = 1'b0;
    logic [3:0]   gnt;
    logic         s1, s0, valid;
    logic [W-1:0] y;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: holder index (-1 = idle), pointer, hold count, last select.
    int m_cur = -1;
    int m_ptr = 0;
    int m_cnt = 0;
    int m_sel = 0;

    mux4_rr_arbiter #(.W(W), .HOLD_MAX(HOLD_MAX)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .x0    (xv[0]),
        .x1    (xv[1]),
        .x2    (xv[2]),
        .x3    (xv[3]),
`ifdef MUX_ARB_LOCK_EN
        .lock  (lock_v),
`endif
        .gnt   (gnt),
        .s1    (s1),
        .s0    (s0),
        .valid (valid),
        .y     (y)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_grant(input int k);
        m_cur = k;
        m_cnt = 0;
        m_ptr = (k + 1) % 4;
        m_sel = k;
    endtask

    task automatic model_edge();
        bit others, found;
        int k;
        found = 0;
        if (m_cur < 0) begin
            for (int off = 0; off < 4; off++) begin
                k = (m_ptr + off) % 4;
                if (!found && req[k]) begin model_grant(k); found = 1; end
            end
        end else begin
            others = 0;
            for (int i = 0; i < 4; i++) if (i != m_cur && req[i]) others = 1;
            if (!req[m_cur] || (m_cnt == HOLD_MAX - 1 && others && !lock_v)) begin
                for (int off = 1; off < 4; off++) begin
                    k = (m_cur + off) % 4;
                    if (!found && req[k]) begin model_grant(k); found = 1; end
                end
                if (!found) begin m_cur = -1; m_cnt = 0; end
            end else if (m_cnt < HOLD_MAX - 1) begin
                m_cnt++;
            end
        end
    endtask

    task automatic compare_model();
        logic [3:0]   e_gnt;
        logic [W-1:0] e_y;
        e_gnt = (m_cur >= 0) ? (4'b0001 << m_cur) : 4'b0000;
        e_y   = (m_cur >= 0) ? xv[m_sel] : '0;
        chk("gnt", {28'd0, gnt}, {28'd0, e_gnt});
        chk("valid", {31'd0, valid}, {31'd0, (m_cur >= 0)});
        chk("sel", {30'd0, s1, s0}, 32'(m_sel));
        chk("y", 32'(y), 32'(e_y));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    // Called just after a clock edge; pulses reset between edges.
    task automatic do_reset();
        #1 rst = 1'b1;
        #1;
        m_cur = -1; m_ptr = 0; m_cnt = 0; m_sel = 0;
        compare_model();
        #1 rst = 1'b0;
    endtask

    initial begin
        int held, prev;
        int seq[$];
        for (int i = 0; i < 4; i++) xv[i] = W'(i + 1);

        // Reset state
        rst = 1'b1;
        #2;
        chk("rst_gnt", {28'd0, gnt}, 32'h0);
        chk("rst_valid", {31'd0, valid}, 32'h0);
        chk("rst_y", 32'(y), 32'h0);
        @(posedge clk);
        do_reset();

        // Single requester 2, then asynchronous reset mid-grant
        req = 4'b0100;
        xv[2] = W'(1);
        step();
        chk("r2_gnt", {28'd0, gnt}, 32'h4);
        chk("r2_sel", {30'd0, s1, s0}, 32'h2);
        chk("r2_y", 32'(y), 32'h1);
        step();
        do_reset();
        chk("mid_rst_valid", {31'd0, valid}, 32'h0);
        chk("mid_rst_y", 32'(y), 32'h0);

        // All request; each drops after two granted cycles, requester 0 re-requests
        req = 4'b1111;
        prev = -1; held = 0;
        for (int i = 0; i < 9; i++) begin
            step();
            chk("rr_busy", {31'd0, valid}, 32'h1);
            if (m_cur != prev) begin seq.push_back(m_cur); held = 1; prev = m_cur; end
            else held++;
            if (m_cur == 2 && held == 1) req[0] = 1'b1;
            if (held == 2 && m_cur >= 0) req[m_cur] = 1'b0;
        end
        chk("rr_len", 32'(seq.size()), 32'd5);
        for (int i = 0; i < 5 && i < seq.size(); i++) chk("rr_seq", 32'(seq[i]), 32'(i % 4));

        // Two steady requesters alternate every HOLD_MAX cycles
        req = 4'b0000;
        do_reset();
        req = 4'b0011;
        for (int i = 1; i <= 17; i++) begin
            step();
            if (i == 8)  chk("alt_8", {28'd0, gnt}, 32'h1);
            if (i == 9)  chk("alt_9", {28'd0, gnt}, 32'h2);
            if (i == 16) chk("alt_16", {28'd0, gnt}, 32'h2);
            if (i == 17) chk("alt_17", {28'd0, gnt}, 32'h1);
        end

        // Lone requester saturates, then a competitor preempts immediately
        req = 4'b0000;
        do_reset();
        req = 4'b0001;
        for (int i = 0; i < 20; i++) step();
        chk("sat_hold", {28'd0, gnt}, 32'h1);
        req = 4'b0011;
        step();
        chk("sat_preempt", {28'd0, gnt}, 32'h2);

        // Release of requester 1 with req=1001 searches from index 2
        req = 4'b0000;
        do_reset();
        req = 4'b0010;
        step();
        req = 4'b1001;
        step();
        chk("rel_to3", {28'd0, gnt}, 32'h8);
        req = 4'b0001;
        step();
        chk("rel_to0", {28'd0, gnt}, 32'h1);
        req = 4'b0000;
        step();
        chk("rel_idle_sel", {30'd0, s1, s0}, 32'h0);

`ifdef MUX_ARB_LOCK_EN
        do_reset();
        req = 4'b0011;
        lock_v = 1'b1;
        for (int i = 0; i < 30; i++) step();
        chk("lock_hold", {28'd0, gnt}, 32'h1);
        lock_v = 1'b0;
        step();
        chk("lock_release", {28'd0, gnt}, 32'h2);
`endif

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            for (int j = 0; j < 4; j++) xv[j] = W'($urandom);
`ifdef MUX_ARB_LOCK_EN
            lock_v = ($urandom_range(0, 7) == 0);
`endif
            if ($urandom_range(0, 99) == 0) do_reset();
            else step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
Round-robin arbiter and select sequencer that shares one 4:1 multiplexer datapath between four requesters. It grants one requester at a time and drives the mux select lines s1/s0 from registered state. It also produces the gated mux output. A hold quantum prevents any single requester from monopolising the datapath. It sits between the requester logic and the gate-level 4:1 mux.

Parameters:
W, 1, data width of each mux input and of y.
HOLD_MAX, 8, maximum consecutive cycles a grant is held while other requests are pending (must be >= 2).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous active-high reset.
req  input  4  request per requester; bit i high = requester i wants the datapath.
x0  input  W  data from requester 0.
x1  input  W  data from requester 1.
x2  input  W  data from requester 2.
x3  input  W  data from requester 3.
gnt  output  4  one-hot grant, registered; all zero when idle.
s1  output  1  mux select MSB, registered; equals granted index bit 1.
s0  output  1  mux select LSB, registered; equals granted index bit 0.
valid  output  1  registered; high when a grant is active.
y  output  W  selected data: x[{s1,s0}] when valid, else all zeros (combinational from registered select).
lock  input  1  present only when MUX_ARB_LOCK_EN is defined; see Optional Feature.

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst). All state uses this clock and this reset.
- Reset values:
  - gnt=4'b0000, s1=0, s0=0, valid=0.
  - Internal: state=IDLE, priority pointer ptr=0, hold counter cnt=0.
- State IDLE:
  - If req==0, remain in IDLE.
  - Otherwise grant the first set bit searching ptr, ptr+1, ... mod 4. Go to GRANT.
  - Grant latency is 1 cycle: req sampled at edge k appears as gnt/valid/s after edge k.
- State GRANT, current index c:
  - cnt increments each cycle and saturates at HOLD_MAX-1.
  - Release: if req[c]==0 at an edge, choose the next requester searching c+1, c+2, c+3 mod 4.
    - If one is found, grant it at the same edge. No idle bubble; cnt=0.
    - If none is found, go to IDLE: gnt=0, valid=0, and s1/s0 hold their last value.
  - Preempt: if req[c]==1, cnt==HOLD_MAX-1, and any other req bit is set, rotate to the next requester from c+1 (excluding c). Set cnt=0.
  - Expiry with no other request pending: keep the grant and hold cnt at HOLD_MAX-1. Preemption triggers on the first edge where another request appears.
  - On every new grant to index g, set ptr=(g+1) mod 4.
- gnt is always one-hot or zero. s1/s0 always match the gnt index while valid=1.
- Simultaneous events:
  - Release and preempt in the same cycle: release wins (same next-grant search).
  - A new request arriving in the same cycle as a release is eligible in that cycle's search.
- Reset mid-grant: outputs clear immediately (asynchronous), and ptr returns to 0.
- y is zero whenever valid=0, so no stale data leaks to downstream logic.

Optional Feature:
MUX_ARB_LOCK_EN
- Defined: adds input lock.
  - While valid=1 and lock=1, preemption is suppressed. cnt still saturates.
  - Release via req[c]=0 still works.
  - lock is ignored in IDLE.
- Undefined: port absent. Preemption always applies per Behaviour.

Test Plan:
- Reset then req=4'b0100 held, x2=1 -> one cycle later gnt=4'b0100, s1=1, s0=0, valid=1, y=1. After rst pulse mid-grant -> gnt=0, valid=0, y=0 immediately.
- req=4'b1111 each requester drops its req after 2 granted cycles, HOLD_MAX=8 -> grant sequence 0,1,2,3,0 with no idle cycle between grants.
- req=4'b0011 held constantly, HOLD_MAX=8 -> gnt alternates 0001 for 8 cycles, 0010 for 8 cycles, repeating.
- req=4'b0001 held alone for 20 cycles -> gnt stays 0001. Then req=4'b0011 -> gnt=0010 one cycle later (cnt saturated).
- Grant to 1 released while req=4'b1001 -> next gnt=4'b1000 (search from index 2), then 0001 after 3 releases.
- With MUX_ARB_LOCK_EN: req=4'b0011, lock=1 -> gnt=0001 held for 30 cycles. lock=0 -> gnt=0010 next cycle.
